bcd_hex_counter: RTL and testbench

Parametrised multi-digit up/down counter with synchronous load, selectable hex or BCD digit radix, wrap or saturate at the terminal count, and per-digit 7-segment outputs. It supersedes the fixed 16-bit hex counter used on the board labs. It sits between the switch/key inputs and the HEX displays, and can be cascaded through its terminal-count output.

---
 rtl/bcd_hex_counter_pkg.sv | 53 +++++
 rtl/bcd_hex_counter_seg7_decode.sv | 15 +
 rtl/bcd_hex_counter.sv | 94 +++++++++
 tb/tb_bcd_hex_counter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_hex_counter_pkg.sv
// Shared definitions for the multi-digit hex/BCD counter: digit limits,
// active-low 7-segment glyphs and small per-digit helper functions.
`timescale 1ns/1ps
package bcd_hex_counter_pkg;

  // Largest value a single digit may hold in each radix.
  localparam logic [3:0] DMAX_HEX = 4'hF;
  localparam logic [3:0] DMAX_BCD = 4'h9;

  // Active-low segment patterns, bit 6 = segment a ... bit 0 = segment g.
  // The "9" glyph leaves segment d dark, matching the board displays.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0001100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  // Per-digit maximum for the selected radix.
  function automatic logic [3:0] digit_max(input logic bcd);
    return bcd ? DMAX_BCD : DMAX_HEX;
  endfunction

  // One increment or decrement of a single digit, rolling over at dmax / 0.
  // Values above dmax roll to 0 on increment so a stray code cannot stick.
  function automatic logic [3:0] digit_step(input logic [3:0] v,
                                            input logic       up,
                                            input logic [3:0] dmax);
    if (up) begin
      return (v >= dmax) ? 4'h0 : v + 4'h1;
    end
    return (v == 4'h0) ? dmax : v - 4'h1;
  endfunction

  // Load-path clamp: in decimal mode any digit above 9 becomes 9.
  function automatic logic [3:0] digit_clamp(input logic [3:0] v,
                                             input logic       bcd);
    return (bcd && (v > DMAX_BCD)) ? DMAX_BCD : v;
  endfunction

endpackage

// File: rtl/bcd_hex_counter_seg7_decode.sv
// Single-digit decoder: 4-bit value to active-low 7-segment pattern.
`timescale 1ns/1ps
module seg7_decode
  import bcd_hex_counter_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Pure table lookup; every 4-bit code has a glyph so no default is needed.
  always_comb begin
    seg = SEG_GLYPH[value];
  end

endmodule

// File: rtl/bcd_hex_counter.sv
// Parametrised multi-digit up/down counter with load, hex or BCD digits,
// wrap or saturate at the terminal value, and per-digit 7-segment outputs.
// Tc is combinational so it can drive En of a cascaded instance.
`timescale 1ns/1ps
module bcd_hex_counter
  import bcd_hex_counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int BCD      = 0,
  parameter int SATURATE = 0
) (
  input  logic                  Clk,
  input  logic                  Clr,
  input  logic                  En,
  input  logic                  Up,
  input  logic                  Ld,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  Tc,
  output logic                  Ovf,
  output logic [7*DIGITS-1:0]   Disp
);

  localparam logic       IS_BCD  = (BCD != 0);
  localparam logic       IS_SAT  = (SATURATE != 0);
  localparam logic [3:0] DMAX    = digit_max(IS_BCD);

  logic [4*DIGITS-1:0] q_r;
  logic [4*DIGITS-1:0] q_nxt;
  logic [4*DIGITS-1:0] d_ld;
  logic                ovf_r;

  // all_max[i] / all_zero[i]: every digit below i sits at DMAX / 0.
  // Index DIGITS therefore marks the whole counter at its terminal value.
  logic [DIGITS:0]     all_max;
  logic [DIGITS:0]     all_zero;
  logic [DIGITS-1:0]   step_en;
  logic                at_term;

  assign all_max[0]  = 1'b1;
  assign all_zero[0] = 1'b1;

  // Carry/borrow chain: identical next-state logic replicated per digit.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] q_dig;

    assign q_dig         = q_r[4*i +: 4];
    assign all_max[i+1]  = all_max[i]  & (q_dig == DMAX);
    assign all_zero[i+1] = all_zero[i] & (q_dig == 4'h0);
    assign step_en[i]    = Up ? all_max[i] : all_zero[i];

    // Next digit value when counting: step only if the lower digits ripple.
    always_comb begin
      q_nxt[4*i +: 4] = step_en[i] ? digit_step(q_dig, Up, DMAX) : q_dig;
    end

    // Load value with the decimal clamp applied digit by digit.
    always_comb begin
      d_ld[4*i +: 4] = digit_clamp(D[4*i +: 4], IS_BCD);
    end

    seg7_decode u_seg (
      .value (q_dig),
      .seg   (Disp[7*i +: 7])
    );
  end

  assign at_term = Up ? all_max[DIGITS] : all_zero[DIGITS];

  // Count register and overflow flag; priority Clr > Ld > En > hold.
  // At the terminal value the chain itself produces the wrapped value,
  // so saturation only has to suppress the update.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      q_r   <= '0;
      ovf_r <= 1'b0;
    end else if (Ld) begin
      q_r   <= d_ld;
      ovf_r <= 1'b0;
    end else if (En) begin
      ovf_r <= at_term;
      if (!(at_term && IS_SAT)) begin
        q_r <= q_nxt;
      end
    end else begin
      ovf_r <= 1'b0;
    end
  end

  assign Q   = q_r;
  assign Ovf = ovf_r;
  assign Tc  = En & at_term;

endmodule

// File: tb/tb_bcd_hex_counter.sv
// Bench for bcd_hex_counter: four configurations share one stimulus stream
// and are each compared against an integer-valued model of the counter.
`timescale 1ns/1ps
module tb_bcd_hex_counter;

  // ---------------- clock / reset ----------------
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic        Clr, En, Up, Ld;
  logic [15:0] D;

  logic [15:0] q_hex, q_bcd, q_sat;
  logic [7:0]  q_bs;
  logic        tc_hex, tc_bcd, tc_sat, tc_bs;
  logic        ovf_hex, ovf_bcd, ovf_sat, ovf_bs;
  logic [27:0] disp_hex, disp_bcd, disp_sat;
  logic [13:0] disp_bs;

  bcd_hex_counter #(.DIGITS(4), .BCD(0), .SATURATE(0)) u_hex (
    .Clk(clk), .Clr(Clr), .En(En), .Up(Up), .Ld(Ld), .D(D),
    .Q(q_hex), .Tc(tc_hex), .Ovf(ovf_hex), .Disp(disp_hex));
  bcd_hex_counter #(.DIGITS(4), .BCD(1), .SATURATE(0)) u_bcd (
    .Clk(clk), .Clr(Clr), .En(En), .Up(Up), .Ld(Ld), .D(D),
    .Q(q_bcd), .Tc(tc_bcd), .Ovf(ovf_bcd), .Disp(disp_bcd));
  bcd_hex_counter #(.DIGITS(4), .BCD(0), .SATURATE(1)) u_sat (
    .Clk(clk), .Clr(Clr), .En(En), .Up(Up), .Ld(Ld), .D(D),
    .Q(q_sat), .Tc(tc_sat), .Ovf(ovf_sat), .Disp(disp_sat));
  bcd_hex_counter #(.DIGITS(2), .BCD(1), .SATURATE(1)) u_bs (
    .Clk(clk), .Clr(Clr), .En(En), .Up(Up), .Ld(Ld), .D(D[7:0]),
    .Q(q_bs), .Tc(tc_bs), .Ovf(ovf_bs), .Disp(disp_bs));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each instance is modelled as one integer in 0..radix**digits-1.
  int cfg_dig [4] = '{4, 4, 4, 2};
  bit cfg_bcd [4] = '{0, 1, 0, 1};
  bit cfg_sat [4] = '{0, 0, 1, 1};

  int mval [4];
  bit movf [4];

  logic [6:0] glyph [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  logic [15:0] exp_q [$];

  function automatic int ipow(int b, int e);
    int r = 1;
    for (int k = 0; k < e; k++) r = r * b;
    return r;
  endfunction

  function automatic int radix_of(int i);
    return cfg_bcd[i] ? 10 : 16;
  endfunction

  function automatic int max_of(int i);
    return ipow(radix_of(i), cfg_dig[i]) - 1;
  endfunction

  function automatic int load_val(int i, logic [15:0] d);
    int v = 0;
    for (int k = 0; k < cfg_dig[i]; k++) begin
      int dk = int'((d >> (4 * k)) & 16'hF);
      if (cfg_bcd[i] && dk > 9) dk = 9;
      v += dk * ipow(radix_of(i), k);
    end
    return v;
  endfunction

  function automatic logic [15:0] to_q(int i, int v);
    logic [15:0] q = '0;
    for (int k = 0; k < cfg_dig[i]; k++)
      q[4*k +: 4] = 4'((v / ipow(radix_of(i), k)) % radix_of(i));
    return q;
  endfunction

  function automatic logic [27:0] to_disp(int i, logic [15:0] q);
    logic [27:0] s = '0;
    for (int k = 0; k < cfg_dig[i]; k++) s[7*k +: 7] = glyph[q[4*k +: 4]];
    return s;
  endfunction

  function automatic bit model_tc(int i, logic en, logic up);
    return en && (up ? (mval[i] == max_of(i)) : (mval[i] == 0));
  endfunction

  task automatic model_step(int i, logic clr, logic ld, logic en, logic up, logic [15:0] d);
    if (clr) begin
      mval[i] = 0; movf[i] = 0;
    end else if (ld) begin
      mval[i] = load_val(i, d); movf[i] = 0;
    end else if (en) begin
      if (up) begin
        if (mval[i] == max_of(i)) begin
          movf[i] = 1;
          if (!cfg_sat[i]) mval[i] = 0;
        end else begin
          mval[i]++; movf[i] = 0;
        end
      end else begin
        if (mval[i] == 0) begin
          movf[i] = 1;
          if (!cfg_sat[i]) mval[i] = max_of(i);
        end else begin
          mval[i]--; movf[i] = 0;
        end
      end
    end else begin
      movf[i] = 0;
    end
  endtask

  // ---------------- DUT observation ----------------
  function automatic logic [15:0] obs_q(int i);
    case (i)
      0: return q_hex;
      1: return q_bcd;
      2: return q_sat;
      default: return {8'h00, q_bs};
    endcase
  endfunction

  function automatic logic obs_ovf(int i);
    case (i)
      0: return ovf_hex;
      1: return ovf_bcd;
      2: return ovf_sat;
      default: return ovf_bs;
    endcase
  endfunction

  function automatic logic obs_tc(int i);
    case (i)
      0: return tc_hex;
      1: return tc_bcd;
      2: return tc_sat;
      default: return tc_bs;
    endcase
  endfunction

  function automatic logic [27:0] obs_disp(int i);
    case (i)
      0: return disp_hex;
      1: return disp_bcd;
      2: return disp_sat;
      default: return {14'h0, disp_bs};
    endcase
  endfunction

  // ---------------- driver ----------------
  // Inputs change on the falling edge; Tc is sampled before the rising edge,
  // registered outputs 1 ns after it.
  task automatic do_cycle(input logic clr, input logic ld, input logic en,
                          input logic up, input logic [15:0] d);
    @(negedge clk);
    Clr = clr; Ld = ld; En = en; Up = up; D = d;
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("tc[%0d]", i), {31'h0, obs_tc(i)}, {31'h0, model_tc(i, en, up)});
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      model_step(i, clr, ld, en, up, d);
      exp_q.push_back(to_q(i, mval[i]));
    end
    for (int i = 0; i < 4; i++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      check($sformatf("q[%0d]", i), {16'h0, obs_q(i)}, {16'h0, e});
      check($sformatf("ovf[%0d]", i), {31'h0, obs_ovf(i)}, {31'h0, movf[i]});
      check($sformatf("disp[%0d]", i), {4'h0, obs_disp(i)}, {4'h0, to_disp(i, e)});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] d_r;
    Clr = 1'b0; Ld = 1'b0; En = 1'b0; Up = 1'b1; D = '0;
    for (int i = 0; i < 4; i++) begin mval[i] = 0; movf[i] = 0; end

    // Reset with En held high.
    do_cycle(1, 0, 1, 1, 16'h0);
    do_cycle(1, 0, 1, 1, 16'h0);
    check("reset_q", {16'h0, q_hex}, 32'h0);
    check("reset_ovf", {31'h0, ovf_hex}, 32'h0);
    check("reset_disp", {4'h0, disp_hex}, {4'h0, {4{7'b0000001}}});

    // Hex wrap up.
    do_cycle(0, 1, 0, 1, 16'hFFFE);
    do_cycle(0, 0, 1, 1, 16'h0);
    check("hexwrap_q1", {16'h0, q_hex}, 32'hFFFF);
    check("hexwrap_tc", {31'h0, tc_hex}, 32'h1);
    do_cycle(0, 0, 1, 1, 16'h0);
    check("hexwrap_q2", {16'h0, q_hex}, 32'h0000);
    check("hexwrap_ovf2", {31'h0, ovf_hex}, 32'h1);
    do_cycle(0, 0, 1, 1, 16'h0);
    check("hexwrap_q3", {16'h0, q_hex}, 32'h0001);
    check("hexwrap_ovf3", {31'h0, ovf_hex}, 32'h0);

    // BCD carry then borrow.
    do_cycle(0, 1, 0, 1, 16'h0999);
    do_cycle(0, 0, 1, 1, 16'h0);
    check("bcd_carry", {16'h0, q_bcd}, 32'h1000);
    check("bcd_carry_ovf", {31'h0, ovf_bcd}, 32'h0);
    do_cycle(0, 0, 1, 0, 16'h0);
    check("bcd_borrow", {16'h0, q_bcd}, 32'h0999);
    check("bcd_borrow_ovf", {31'h0, ovf_bcd}, 32'h0);

    // BCD load clamp.
    do_cycle(0, 1, 0, 1, 16'h12AF);
    check("bcd_clamp", {16'h0, q_bcd}, 32'h1299);
    check("bcd_clamp_disp0", {25'h0, disp_bcd[6:0]}, {25'h0, 7'b0001100});

    // Saturate at zero counting down.
    do_cycle(1, 0, 0, 1, 16'h0);
    for (int n = 0; n < 3; n++) begin
      do_cycle(0, 0, 1, 0, 16'h0);
      check("sat_q", {16'h0, q_sat}, 32'h0);
      check("sat_ovf", {31'h0, ovf_sat}, 32'h1);
      check("sat_tc", {31'h0, tc_sat}, 32'h1);
    end
    do_cycle(0, 0, 1, 1, 16'h0);
    check("sat_up_q", {16'h0, q_sat}, 32'h0001);
    check("sat_up_ovf", {31'h0, ovf_sat}, 32'h0);

    // Priority.
    do_cycle(1, 1, 1, 1, 16'h1234);
    check("prio_clr_ld", {16'h0, q_hex}, 32'h0);
    do_cycle(0, 1, 1, 1, 16'h0042);
    check("prio_ld_en", {16'h0, q_hex}, 32'h0042);
    for (int n = 0; n < 5; n++) begin
      do_cycle(0, 0, 0, 1, 16'h0);
      check("hold", {16'h0, q_hex}, 32'h0042);
    end

    // Randomized traffic biased toward the terminal values.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: d_r = 16'hFFFF - 16'($urandom_range(0, 2));
        1: d_r = 16'h9999 - 16'($urandom_range(0, 2));
        2: d_r = 16'($urandom_range(0, 2));
        default: d_r = 16'($urandom);
      endcase
      do_cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), d_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
